// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs and an RX interrupt for the MEM-stage bus.
// Define UART_PARITY_EN to add an even-parity bit to both directions (CON b7 = parity error).
module uart_mmio_fifo #(
  parameter int BAUD_DIV   = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        in,
  output logic        out,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
`endif

  logic txd_sel_s, rxd_sel_s, con_sel_s, con_rd_s, con_wr_s;
  assign txd_sel_s = (addr[31:2] == 30'h1000_0006);
  assign rxd_sel_s = (addr[31:2] == 30'h1000_0007);
  assign con_sel_s = (addr[31:2] == 30'h1000_0008);
  assign con_rd_s  = rd & con_sel_s;
  assign con_wr_s  = wr & con_sel_s;

  logic unused_s;
  assign unused_s = ^{addr[1:0], wdata[31:8]};

  // ---------------- FIFOs ----------------
  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
  logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic [7:0]  tx_head_s, rx_head_s;

  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full_s  = (tx_wp_r[AW] != tx_rp_r[AW]) && (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);
  assign rx_empty_s = (rx_wp_r == rx_rp_r);
  assign rx_full_s  = (rx_wp_r[AW] != rx_rp_r[AW]) && (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
  assign tx_head_s  = tx_mem_r[tx_rp_r[AW-1:0]];
  assign rx_head_s  = rx_mem_r[rx_rp_r[AW-1:0]];

  uart_state_t tx_state_r, rx_state_r;
  logic        rx_stop_ok_s, rx_frame_err_s;
  logic [7:0]  rx_shift_r;

  assign tx_push_s = wr & txd_sel_s & ~tx_full_s;
  assign tx_pop_s  = (tx_state_r == S_IDLE) & ~tx_empty_s;
  assign rx_pop_s  = rd & rxd_sel_s & ~rx_empty_s;
  // A pop in the same cycle frees the slot the arriving byte needs.
  assign rx_push_s = rx_stop_ok_s & (~rx_full_s | rx_pop_s);

  // TX FIFO storage and pointers
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      tx_wp_r <= PTR_ZERO;
      tx_rp_r <= PTR_ZERO;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wp_r[AW-1:0]] <= wdata[7:0];
        tx_wp_r <= tx_wp_r + PTR_ONE;
      end
      if (tx_pop_s) tx_rp_r <= tx_rp_r + PTR_ONE;
    end
  end

  // RX FIFO storage and pointers
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      rx_wp_r <= PTR_ZERO;
      rx_rp_r <= PTR_ZERO;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wp_r[AW-1:0]] <= rx_shift_r;
        rx_wp_r <= rx_wp_r + PTR_ONE;
      end
      if (rx_pop_s) rx_rp_r <= rx_rp_r + PTR_ONE;
    end
  end

  // ---------------- transmitter ----------------
  logic [CW-1:0] tx_cnt_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          tx_par_r, out_r;

  // TX framing FSM; out is driven straight from a flop
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      tx_state_r <= S_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_par_r   <= 1'b0;
      out_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        S_IDLE: begin
          if (!tx_empty_s) begin
            tx_shift_r <= tx_head_s;
            tx_par_r   <= ^tx_head_s;
            out_r      <= 1'b0;
            tx_cnt_r   <= BIT_LOAD;
            tx_state_r <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_r != CNT_ZERO) tx_cnt_r <= tx_cnt_r - CNT_ONE;
          else begin
            out_r      <= tx_shift_r[0];
            tx_cnt_r   <= BIT_LOAD;
            tx_bit_r   <= 3'd0;
            tx_state_r <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_cnt_r != CNT_ZERO) tx_cnt_r <= tx_cnt_r - CNT_ONE;
          else begin
            tx_cnt_r <= BIT_LOAD;
            if (tx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
              out_r      <= tx_par_r;
              tx_state_r <= S_PARITY;
`else
              out_r      <= 1'b1;
              tx_state_r <= S_STOP;
`endif
            end else begin
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              out_r      <= tx_shift_r[1];
              tx_bit_r   <= tx_bit_r + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (tx_cnt_r != CNT_ZERO) tx_cnt_r <= tx_cnt_r - CNT_ONE;
          else begin
            out_r      <= 1'b1;
            tx_cnt_r   <= BIT_LOAD;
            tx_state_r <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tx_cnt_r != CNT_ZERO) tx_cnt_r <= tx_cnt_r - CNT_ONE;
          else tx_state_r <= S_IDLE;
        end
        default: begin
          out_r      <= 1'b1;
          tx_state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign out = out_r;

  // ---------------- receiver ----------------
  logic          in_meta_r, in_sync_r, in_prev_r;
  logic [CW-1:0] rx_cnt_r;
  logic [2:0]    rx_bit_r;
`ifdef UART_PARITY_EN
  logic          rx_par_bad_r;
`endif

  assign rx_stop_ok_s   = (rx_state_r == S_STOP) && (rx_cnt_r == CNT_ZERO) &&  in_sync_r;
  assign rx_frame_err_s = (rx_state_r == S_STOP) && (rx_cnt_r == CNT_ZERO) && !in_sync_r;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      in_meta_r <= 1'b1;
      in_sync_r <= 1'b1;
      in_prev_r <= 1'b1;
    end else begin
      in_meta_r <= in;
      in_sync_r <= in_meta_r;
      in_prev_r <= in_sync_r;
    end
  end

  // RX framing FSM; the first wait is half a bit so later samples land mid-bit
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      rx_state_r   <= S_IDLE;
      rx_cnt_r     <= CNT_ZERO;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'h00;
`ifdef UART_PARITY_EN
      rx_par_bad_r <= 1'b0;
`endif
    end else begin
      case (rx_state_r)
        S_IDLE: begin
          if (in_prev_r && !in_sync_r) begin
            rx_cnt_r   <= HALF_LOAD;
            rx_state_r <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_r != CNT_ZERO) rx_cnt_r <= rx_cnt_r - CNT_ONE;
          else if (in_sync_r) rx_state_r <= S_IDLE;
          else begin
            rx_cnt_r   <= BIT_LOAD;
            rx_bit_r   <= 3'd0;
            rx_state_r <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt_r != CNT_ZERO) rx_cnt_r <= rx_cnt_r - CNT_ONE;
          else begin
            rx_shift_r <= {in_sync_r, rx_shift_r[7:1]};
            rx_cnt_r   <= BIT_LOAD;
            rx_bit_r   <= rx_bit_r + 3'd1;
`ifdef UART_PARITY_EN
            if (rx_bit_r == 3'd7) rx_state_r <= S_PARITY;
`else
            if (rx_bit_r == 3'd7) rx_state_r <= S_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_cnt_r != CNT_ZERO) rx_cnt_r <= rx_cnt_r - CNT_ONE;
          else begin
            rx_par_bad_r <= in_sync_r ^ (^rx_shift_r);
            rx_cnt_r     <= BIT_LOAD;
            rx_state_r   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (rx_cnt_r != CNT_ZERO) rx_cnt_r <= rx_cnt_r - CNT_ONE;
          else rx_state_r <= S_IDLE;
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end

  // ---------------- status, irq, read mux ----------------
  logic ovr_r, fe_r, ie_r, irq_r, pe_bit_s;
`ifdef UART_PARITY_EN
  logic pe_r;
  assign pe_bit_s = pe_r;
`else
  assign pe_bit_s = 1'b0;
`endif

  // Sticky error flags (set wins over the clear-on-read), irq enable and registered irq
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      ovr_r <= 1'b0;
      fe_r  <= 1'b0;
      ie_r  <= 1'b0;
      irq_r <= 1'b0;
`ifdef UART_PARITY_EN
      pe_r  <= 1'b0;
`endif
    end else begin
      ovr_r <= (rx_stop_ok_s & rx_full_s & ~rx_pop_s) | (ovr_r & ~con_rd_s);
      fe_r  <= rx_frame_err_s | (fe_r & ~con_rd_s);
      ie_r  <= con_wr_s ? wdata[5] : ie_r;
      irq_r <= ie_r & ~rx_empty_s;
`ifdef UART_PARITY_EN
      pe_r  <= (rx_stop_ok_s & rx_par_bad_r) | (pe_r & ~con_rd_s);
`endif
    end
  end

  assign irq = irq_r;

  logic [31:0] con_val_s;
  assign con_val_s = {24'h00_0000, pe_bit_s, (tx_state_r != S_IDLE), ie_r, fe_r, ovr_r,
                      ~rx_empty_s, tx_empty_s, tx_full_s};

  // Load data mux; zero unless a mapped readable register is addressed
  always_comb begin
    rdata = 32'h0000_0000;
    if (rd) begin
      if (rxd_sel_s && !rx_empty_s) rdata = {24'h00_0000, rx_head_s};
      else if (con_sel_s)           rdata = con_val_s;
      else                          rdata = 32'h0000_0000;
    end else begin
      rdata = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo at BAUD_DIV=16, FIFO_DEPTH=4.
module tb_uart_mmio_fifo;
  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam logic [31:0] A_BAD = 32'h4000_0024;

  logic        CLK = 1'b0, Reset_n = 1'b0, rd = 1'b0, wr = 1'b0, in = 1'b1;
  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata;
  logic        out, irq;
  int          checks = 0, passed = 0;
`ifdef UART_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  always #5 CLK = ~CLK;

  uart_mmio_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .in(in), .out(out), .irq(irq)
  );

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK); addr = a; wdata = d; wr = 1'b1;
    @(negedge CLK); wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK); addr = a; rd = 1'b1;
    #1 d = rdata;
    @(negedge CLK); rd = 1'b0; addr = 32'h0;
  endtask

  // Waits (bounded) for a start bit on out and samples every bit at mid-bit; returns at mid-stop.
  task automatic tx_capture(output logic [7:0] data, output logic [1:0] frm,
                            output logic perr, output int wait_n);
    wait_n = 0; data = 8'h00; frm = 2'b00; perr = 1'b0;
    while (out !== 1'b0 && wait_n < 500) begin @(negedge CLK); wait_n++; end
    if (out === 1'b0) begin
      repeat (7) @(negedge CLK);
      frm[0] = out;
      for (int i = 0; i < 8; i++) begin repeat (BAUD) @(negedge CLK); data[i] = out; end
`ifdef UART_PARITY_EN
      repeat (BAUD) @(negedge CLK);
      perr = out ^ (^data);
`endif
      repeat (BAUD) @(negedge CLK);
      frm[1] = out;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge CLK); in = 1'b0;
    repeat (BAUD) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin in = b[i]; repeat (BAUD) @(negedge CLK); end
`ifdef UART_PARITY_EN
    in = (^b) ^ par_flip;
    repeat (BAUD) @(negedge CLK);
`endif
    in = stop_bit;
    repeat (BAUD) @(negedge CLK);
    in = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    Reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    addr = A_CON;
    checks++; if (out !== 1'b1) $display("FAIL reset_out got %b want 1", out); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL rdata_no_rd got %h want 0", rdata); else passed++;
    addr = 32'h0; Reset_n = 1'b1;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL reset_con got %h want 02", d); else passed++;
  endtask

  task automatic test_tx_single();
    logic [7:0] b; logic [1:0] f; logic pe; int w; logic [31:0] d;
    cpu_write(A_TXD, 32'h0000_00A5);
    tx_capture(b, f, pe, w);
    checks++; if (w > 2) $display("FAIL tx_latency got %0d want <=2", w); else passed++;
    checks++; if (b !== 8'hA5) $display("FAIL tx_data got %h want a5", b); else passed++;
    checks++; if (f !== 2'b10) $display("FAIL tx_framing got %b want 10", f); else passed++;
    checks++; if (pe !== 1'b0) $display("FAIL tx_parity got %b want 0", pe); else passed++;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h42) $display("FAIL tx_busy_con got %h want 42", d); else passed++;
    repeat (20) @(negedge CLK);
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL tx_done_con got %h want 02", d); else passed++;
  endtask

  task automatic test_tx_overflow();
    logic [7:0] b; logic [1:0] f; logic pe; int w; logic [31:0] d;
    // 0xFF keeps the transmitter busy so the next four writes fill the FIFO and the fifth is dropped
    cpu_write(A_TXD, 32'h0000_00FF);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); addr = A_TXD; wdata = 32'h11 + i; wr = 1'b1;
    end
    @(negedge CLK); wr = 1'b0; addr = 32'h0;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h41) $display("FAIL tx_full_con got %h want 41", d); else passed++;
    w = 0;
    while (out !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
    for (int i = 0; i < 4; i++) begin
      tx_capture(b, f, pe, w);
      checks++; if (b !== 8'(8'h11 + i)) $display("FAIL tx_ovf_data%0d got %h want %h", i, b, 8'(8'h11 + i)); else passed++;
      checks++; if (f !== 2'b10) $display("FAIL tx_ovf_frm%0d got %b want 10", i, f); else passed++;
      if (i > 0) begin
        checks++; if (w > 10) $display("FAIL tx_gap%0d got %0d want <=10", i, w); else passed++;
      end
    end
    repeat (40) @(negedge CLK);
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL tx_dropped_con got %h want 02", d); else passed++;
  endtask

  task automatic test_tx_reset_abort();
    logic [31:0] d;
    cpu_write(A_TXD, 32'h0000_0000);
    cpu_write(A_TXD, 32'h0000_0000);
    repeat (20) @(negedge CLK);
    checks++; if (out !== 1'b0) $display("FAIL abort_midframe got %b want 0", out); else passed++;
    Reset_n = 1'b0;
    @(negedge CLK);
    checks++; if (out !== 1'b1) $display("FAIL abort_out got %b want 1", out); else passed++;
    Reset_n = 1'b1;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL abort_con got %h want 02", d); else passed++;
  endtask

  task automatic test_rx_irq();
    logic [31:0] d;
    cpu_write(A_CON, 32'h0000_0020);
    @(negedge CLK);
    checks++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else passed++;
    send_frame(8'h3C, 1'b1);
    checks++; if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq); else passed++;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h26) $display("FAIL rx_con got %h want 26", d); else passed++;
    cpu_read(A_RXD, d);
    checks++; if (d !== 32'h3C) $display("FAIL rx_data got %h want 3c", d); else passed++;
    @(negedge CLK);
    checks++; if (irq !== 1'b0) $display("FAIL irq_fall got %b want 0", irq); else passed++;
    cpu_read(A_RXD, d);
    checks++; if (d !== 32'h0) $display("FAIL rx_empty_read got %h want 0", d); else passed++;
    cpu_write(A_CON, 32'h0000_0000);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h0E) $display("FAIL ovr_con got %h want 0e", d); else passed++;
    for (int i = 1; i <= 4; i++) begin
      cpu_read(A_RXD, d);
      checks++; if (d !== 32'(i)) $display("FAIL ovr_data%0d got %h want %h", i, d, 32'(i)); else passed++;
    end
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL ovr_clear got %h want 02", d); else passed++;
  endtask

  task automatic test_rx_frame_err();
    logic [31:0] d;
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge CLK);
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h12) $display("FAIL fe_con got %h want 12", d); else passed++;
    cpu_read(A_RXD, d);
    checks++; if (d !== 32'h0) $display("FAIL fe_nopush got %h want 0", d); else passed++;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL fe_clear got %h want 02", d); else passed++;
  endtask

  task automatic test_rx_glitch();
    logic [31:0] d;
    @(negedge CLK); in = 1'b0;
    repeat (3) @(negedge CLK); in = 1'b1;
    repeat (200) @(negedge CLK);
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h02) $display("FAIL glitch_con got %h want 02", d); else passed++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    cpu_read(A_BAD, d);
    checks++; if (d !== 32'h0) $display("FAIL unmapped got %h want 0", d); else passed++;
    cpu_read(A_TXD, d);
    checks++; if (d !== 32'h0) $display("FAIL txd_read got %h want 0", d); else passed++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [31:0] d;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    cpu_read(A_CON, d);
    checks++; if (d !== 32'h86) $display("FAIL par_con got %h want 86", d); else passed++;
    cpu_read(A_RXD, d);
    checks++; if (d !== 32'h07) $display("FAIL par_data got %h want 07", d); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_tx_reset_abort();
    test_rx_irq();
    test_rx_overrun();
    test_rx_frame_err();
    test_rx_glitch();
    test_unmapped();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
